bp_me_dma_arbiter: RTL and testbench

- Shares one cache-DMA memory port among num_dma_p L2 cache DMA requesters. Sits between the L2 banks and the DRAM backend (dramsim3, dmc or AXI bridge).
- Picks the next DMA packet by round-robin, records which requester owns each read fill and each write drain, and steers the fill-width data beats to or from the owning requester.
- Beats are delivered in order, one block per packet.

---
 rtl/bp_me_dma_arbiter_pkg.sv | 20 ++
 rtl/bp_me_dma_owner_fifo.sv | 53 +++++
 rtl/bp_me_dma_arbiter.sv | 154 +++++++++++++++
 tb/tb_bp_me_dma_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_dma_arbiter_pkg.sv
// Shared types and sizing helpers for the cache-DMA arbiter.
package bp_me_dma_arbiter_pkg;

  localparam int dma_addr_width_lp = 40;
  localparam int block_beats_lp    = 8;

  // A cache-DMA packet: direction bit on top, address below it.
  typedef struct packed {
    logic                         write_not_read;
    logic [dma_addr_width_lp-1:0] addr;
  } bp_me_dma_pkt_s;

  // $clog2 that never returns 0, so single-entry sizes still get a 1-bit field.
  function automatic int clog2_min1(input int val);
    return (val > 1) ? $clog2(val) : 1;
  endfunction

  localparam int beat_cnt_width_lp = clog2_min1(block_beats_lp);

endpackage

// File: rtl/bp_me_dma_owner_fifo.sv
// Small FIFO of requester ids; records which requester owns each in-flight block.
module bp_me_dma_owner_fifo
  import bp_me_dma_arbiter_pkg::*;
#(
  parameter int els_p   = 4,
  parameter int width_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int ptr_width_lp = clog2_min1(els_p);
  localparam int cnt_width_lp = $clog2(els_p + 1);
  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);

  logic [width_p-1:0]      mem [els_p];
  logic [ptr_width_lp-1:0] rd_ptr_r, wr_ptr_r;
  logic [cnt_width_lp-1:0] count_r;
  logic                    do_push, do_pop;

  // A pop frees the head slot in the same cycle, so a push into a full FIFO is fine then.
  assign do_pop  = yumi_i & ~empty_o;
  assign do_push = v_i & (~full_o | do_pop);
  assign empty_o = (count_r == '0);
  assign full_o  = (count_r == cnt_width_lp'(els_p));
  assign data_o  = mem[rd_ptr_r];

  // Pointers wrap explicitly so depths that are not powers of two work.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push) wr_ptr_r <= (wr_ptr_r == last_ptr_lp) ? '0 : wr_ptr_r + 1'b1;
      if (do_pop)  rd_ptr_r <= (rd_ptr_r == last_ptr_lp) ? '0 : rd_ptr_r + 1'b1;
      if (do_push && !do_pop)      count_r <= count_r + 1'b1;
      else if (do_pop && !do_push) count_r <= count_r - 1'b1;
    end
  end

  // Id storage needs no reset; the empty flag masks stale entries.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_r] <= data_i;
  end

endmodule

// File: rtl/bp_me_dma_arbiter.sv
// Round-robin arbiter sharing one memory DMA port among several L2 cache requesters.
module bp_me_dma_arbiter
  import bp_me_dma_arbiter_pkg::*;
#(
  parameter int num_dma_p       = 4,
  parameter int dma_pkt_width_p = 41,
  parameter int fill_width_p    = 64,
  parameter int block_beats_p   = block_beats_lp,
  parameter int rd_els_p        = 4,
  parameter int wr_els_p        = 2
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [num_dma_p*dma_pkt_width_p-1:0] dma_pkt_i,
  input  logic [num_dma_p-1:0]                 dma_pkt_v_i,
  output logic [num_dma_p-1:0]                 dma_pkt_yumi_o,
  output logic [num_dma_p*fill_width_p-1:0]    dma_data_o,
  output logic [num_dma_p-1:0]                 dma_data_v_o,
  input  logic [num_dma_p-1:0]                 dma_data_ready_and_i,
  input  logic [num_dma_p*fill_width_p-1:0]    dma_data_i,
  input  logic [num_dma_p-1:0]                 dma_data_v_i,
  output logic [num_dma_p-1:0]                 dma_data_yumi_o,
  output logic [dma_pkt_width_p-1:0]           mem_pkt_o,
  output logic                                 mem_pkt_v_o,
  input  logic                                 mem_pkt_ready_and_i,
  input  logic [fill_width_p-1:0]              mem_data_i,
  input  logic                                 mem_data_v_i,
  output logic                                 mem_data_ready_and_o,
  output logic [fill_width_p-1:0]              mem_data_o,
  output logic                                 mem_data_v_o,
  input  logic                                 mem_data_ready_and_i
);

  localparam int id_width_lp  = clog2_min1(num_dma_p);
  localparam int cnt_width_lp = clog2_min1(block_beats_p);
  localparam logic [id_width_lp-1:0]  last_id_lp   = id_width_lp'(num_dma_p - 1);
  localparam logic [cnt_width_lp-1:0] last_beat_lp = cnt_width_lp'(block_beats_p - 1);

  logic [num_dma_p-1:0]    eligible;
  logic [id_width_lp-1:0]  ptr_r, lock_id_r, scan_id, grant_id, rd_head, wr_head;
  logic                    lock_r, grant_found, accept, grant_write;
  logic                    rd_full, rd_empty, wr_full, wr_empty;
  logic                    rd_push, wr_push, rd_hs, wr_hs, rd_pop, wr_pop;
  logic [cnt_width_lp-1:0] rd_cnt_r, wr_cnt_r;

  // A requester only competes if the owner FIFO for its direction has room.
  for (genvar i = 0; i < num_dma_p; i++) begin : g_elig
    assign eligible[i] = dma_pkt_v_i[i]
                       & (dma_pkt_i[i*dma_pkt_width_p + dma_pkt_width_p - 1] ? ~wr_full : ~rd_full);
  end

  // Round-robin search: first eligible index at or after the pointer, wrapping.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    scan_id     = '0;
    idx         = 0;
    for (int k = 0; k < num_dma_p; k++) begin
      idx = int'(ptr_r) + k;
      if (idx >= num_dma_p) idx = idx - num_dma_p;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        scan_id     = id_width_lp'(idx);
      end
    end
  end

  // A stalled packet keeps its grant so a newly valid requester cannot preempt it.
  assign grant_id    = lock_r ? lock_id_r : scan_id;
  assign mem_pkt_v_o = reset_n_i & (lock_r | grant_found);
  assign mem_pkt_o   = dma_pkt_i[grant_id*dma_pkt_width_p +: dma_pkt_width_p];
  assign accept      = mem_pkt_v_o & mem_pkt_ready_and_i;
  assign grant_write = mem_pkt_o[dma_pkt_width_p-1];
  assign rd_push     = accept & ~grant_write;
  assign wr_push     = accept &  grant_write;

  // Pointer advance past the accepted requester and grant lock bookkeeping.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_r     <= '0;
      lock_r    <= 1'b0;
      lock_id_r <= '0;
    end else if (accept) begin
      ptr_r  <= (grant_id == last_id_lp) ? '0 : grant_id + 1'b1;
      lock_r <= 1'b0;
    end else if (mem_pkt_v_o) begin
      lock_r    <= 1'b1;
      lock_id_r <= grant_id;
    end
  end

  // Read fills and write drains flow independently; the data paths key off each FIFO head.
  assign mem_data_ready_and_o = ~rd_empty & dma_data_ready_and_i[rd_head];
  assign rd_hs                = mem_data_v_i & mem_data_ready_and_o;
  assign rd_pop               = rd_hs & (rd_cnt_r == last_beat_lp);
  assign dma_data_o           = {num_dma_p{mem_data_i}};

  assign mem_data_v_o = ~wr_empty & dma_data_v_i[wr_head];
  assign mem_data_o   = dma_data_i[wr_head*fill_width_p +: fill_width_p];
  assign wr_hs        = mem_data_v_o & mem_data_ready_and_i;
  assign wr_pop       = wr_hs & (wr_cnt_r == last_beat_lp);

  // Steer per-requester strobes to the owner at each FIFO head and to the arbitration winner.
  always_comb begin
    dma_pkt_yumi_o  = '0;
    dma_data_v_o    = '0;
    dma_data_yumi_o = '0;
    for (int i = 0; i < num_dma_p; i++) begin
      dma_pkt_yumi_o[i]  = accept & (grant_id == id_width_lp'(i));
      dma_data_v_o[i]    = mem_data_v_i & ~rd_empty & (rd_head == id_width_lp'(i));
      dma_data_yumi_o[i] = wr_hs & (wr_head == id_width_lp'(i));
    end
  end

  // Beat counters; each wraps on the last beat of a block, which also pops its FIFO.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_cnt_r <= '0;
      wr_cnt_r <= '0;
    end else begin
      if (rd_hs) rd_cnt_r <= rd_pop ? '0 : rd_cnt_r + 1'b1;
      if (wr_hs) wr_cnt_r <= wr_pop ? '0 : wr_cnt_r + 1'b1;
    end
  end

  bp_me_dma_owner_fifo #(
    .els_p   (rd_els_p),
    .width_p (id_width_lp)
  ) rd_owner_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (rd_push),
    .data_i    (grant_id),
    .yumi_i    (rd_pop),
    .data_o    (rd_head),
    .full_o    (rd_full),
    .empty_o   (rd_empty)
  );

  bp_me_dma_owner_fifo #(
    .els_p   (wr_els_p),
    .width_p (id_width_lp)
  ) wr_owner_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (wr_push),
    .data_i    (grant_id),
    .yumi_i    (wr_pop),
    .data_o    (wr_head),
    .full_o    (wr_full),
    .empty_o   (wr_empty)
  );

endmodule

// File: tb/tb_bp_me_dma_arbiter.sv
// Randomized and directed bench for the DMA arbiter against a queue-based reference model.
module tb_bp_me_dma_arbiter;
  import bp_me_dma_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int PW = 41;
  localparam int FW = 64;
  localparam int BB = 8;
  localparam int RD_ELS = 4;
  localparam int WR_ELS = 2;

  logic            clk_i = 1'b0;
  logic            reset_n_i = 1'b1;
  logic [N*PW-1:0] dma_pkt_i = '0;
  logic [N-1:0]    dma_pkt_v_i = '0;
  logic [N-1:0]    dma_pkt_yumi_o;
  logic [N*FW-1:0] dma_data_o;
  logic [N-1:0]    dma_data_v_o;
  logic [N-1:0]    dma_data_ready_and_i = '0;
  logic [N*FW-1:0] dma_data_i = '0;
  logic [N-1:0]    dma_data_v_i = '0;
  logic [N-1:0]    dma_data_yumi_o;
  logic [PW-1:0]   mem_pkt_o;
  logic            mem_pkt_v_o;
  logic            mem_pkt_ready_and_i = 1'b0;
  logic [FW-1:0]   mem_data_i = '0;
  logic            mem_data_v_i = 1'b0;
  logic            mem_data_ready_and_o;
  logic [FW-1:0]   mem_data_o;
  logic            mem_data_v_o;
  logic            mem_data_ready_and_i = 1'b0;

  bp_me_dma_arbiter dut (
    .clk_i                (clk_i),
    .reset_n_i            (reset_n_i),
    .dma_pkt_i            (dma_pkt_i),
    .dma_pkt_v_i          (dma_pkt_v_i),
    .dma_pkt_yumi_o       (dma_pkt_yumi_o),
    .dma_data_o           (dma_data_o),
    .dma_data_v_o         (dma_data_v_o),
    .dma_data_ready_and_i (dma_data_ready_and_i),
    .dma_data_i           (dma_data_i),
    .dma_data_v_i         (dma_data_v_i),
    .dma_data_yumi_o      (dma_data_yumi_o),
    .mem_pkt_o            (mem_pkt_o),
    .mem_pkt_v_o          (mem_pkt_v_o),
    .mem_pkt_ready_and_i  (mem_pkt_ready_and_i),
    .mem_data_i           (mem_data_i),
    .mem_data_v_i         (mem_data_v_i),
    .mem_data_ready_and_o (mem_data_ready_and_o),
    .mem_data_o           (mem_data_o),
    .mem_data_v_o         (mem_data_v_o),
    .mem_data_ready_and_i (mem_data_ready_and_i)
  );

  // Free-running clock; stimulus changes on the falling edge.
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference state: owner queues, round-robin pointer, held grant, beats per block.
  int            rd_q[$];
  int            wr_q[$];
  int            ptr, lock_id, rd_beats, wr_beats;
  bit            lock;
  logic [PW-1:0] pend_pkt [N];
  bit            pend_v   [N];

  // Stimulus knobs, percentages 0..100.
  int p_new, p_write, p_mpr, p_mdv, p_dready, p_wv, p_mdr;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] makePkt(input bit wr);
    bp_me_dma_pkt_s p;
    p.write_not_read = wr;
    p.addr           = {8'($urandom), 32'($urandom)};
    return p;
  endfunction

  function automatic bit hit(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  function automatic bit isEligible(input int i);
    if (!pend_v[i]) return 1'b0;
    if (pend_pkt[i][PW-1]) return wr_q.size() < WR_ELS;
    return rd_q.size() < RD_ELS;
  endfunction

  task automatic setKnobs(input int n, input int w, input int mpr, input int mdv,
                          input int dr, input int wv, input int mdr);
    p_new = n; p_write = w; p_mpr = mpr; p_mdv = mdv; p_dready = dr; p_wv = wv; p_mdr = mdr;
  endtask

  // Requesters hold a packet until accepted; everything else is redrawn each cycle.
  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      if (!pend_v[i] && hit(p_new)) begin
        pend_v[i]   = 1'b1;
        pend_pkt[i] = makePkt(hit(p_write));
      end
      dma_pkt_i[i*PW +: PW]   = pend_pkt[i];
      dma_pkt_v_i[i]          = pend_v[i];
      dma_data_ready_and_i[i] = hit(p_dready);
      dma_data_v_i[i]         = hit(p_wv);
      dma_data_i[i*FW +: FW]  = {$urandom, $urandom};
    end
    mem_pkt_ready_and_i  = hit(p_mpr);
    mem_data_v_i         = hit(p_mdv);
    mem_data_i           = {$urandom, $urandom};
    mem_data_ready_and_i = hit(p_mdr);
  endtask

  // Predicts this cycle's outputs from the rules, compares, then advances the model.
  task automatic modelCheck();
    int         grant, rh, wh;
    bit         exp_pv, accept, exp_mr, exp_mv;
    logic [3:0] exp_yumi, exp_dv, exp_dy;
    #1;
    grant = -1;
    if (lock) grant = lock_id;
    else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (ptr + k) % N;
        if (grant < 0 && isEligible(idx)) grant = idx;
      end
    end
    exp_pv = (grant >= 0);
    checkOutput("mem_pkt_v", 64'(mem_pkt_v_o), 64'(exp_pv));
    if (exp_pv) checkOutput("mem_pkt", 64'(mem_pkt_o), 64'(pend_pkt[grant]));
    accept   = exp_pv && mem_pkt_ready_and_i;
    exp_yumi = accept ? 4'(1 << grant) : 4'b0;
    checkOutput("dma_pkt_yumi", 64'(dma_pkt_yumi_o), 64'(exp_yumi));

    rh     = (rd_q.size() > 0) ? rd_q[0] : 0;
    exp_mr = (rd_q.size() > 0) && dma_data_ready_and_i[rh];
    exp_dv = ((rd_q.size() > 0) && mem_data_v_i) ? 4'(1 << rh) : 4'b0;
    checkOutput("mem_data_ready", 64'(mem_data_ready_and_o), 64'(exp_mr));
    checkOutput("dma_data_v", 64'(dma_data_v_o), 64'(exp_dv));
    for (int j = 0; j < N; j++) checkOutput("dma_data_lane", dma_data_o[j*FW +: FW], mem_data_i);

    wh     = (wr_q.size() > 0) ? wr_q[0] : 0;
    exp_mv = (wr_q.size() > 0) && dma_data_v_i[wh];
    exp_dy = (exp_mv && mem_data_ready_and_i) ? 4'(1 << wh) : 4'b0;
    checkOutput("mem_data_v", 64'(mem_data_v_o), 64'(exp_mv));
    if (exp_mv) checkOutput("mem_data", mem_data_o, dma_data_i[wh*FW +: FW]);
    checkOutput("dma_data_yumi", 64'(dma_data_yumi_o), 64'(exp_dy));

    if (mem_data_v_i && exp_mr) begin
      rd_beats++;
      if (rd_beats == BB) begin rd_beats = 0; void'(rd_q.pop_front()); end
    end
    if (exp_mv && mem_data_ready_and_i) begin
      wr_beats++;
      if (wr_beats == BB) begin wr_beats = 0; void'(wr_q.pop_front()); end
    end
    if (accept) begin
      if (pend_pkt[grant][PW-1]) wr_q.push_back(grant);
      else rd_q.push_back(grant);
      ptr          = (grant + 1) % N;
      lock         = 1'b0;
      pend_v[grant] = 1'b0;
    end else if (exp_pv) begin
      lock    = 1'b1;
      lock_id = grant;
    end
  endtask

  task automatic runCycles(input int n);
    for (int c = 0; c < n; c++) begin
      applyStimulus();
      modelCheck();
      @(negedge clk_i);
    end
  endtask

  // Drops reset with requesters active and checks the outputs clear before any clock edge.
  task automatic asyncResetCheck(input string tag);
    dma_pkt_v_i = '1; mem_data_v_i = 1'b1; dma_data_ready_and_i = '1;
    dma_data_v_i = '1; mem_pkt_ready_and_i = 1'b1; mem_data_ready_and_i = 1'b1;
    reset_n_i = 1'b0;
    #1;
    checkOutput({tag, "_pkt_v"}, 64'(mem_pkt_v_o), 64'd0);
    checkOutput({tag, "_pkt_yumi"}, 64'(dma_pkt_yumi_o), 64'd0);
    checkOutput({tag, "_dma_v"}, 64'(dma_data_v_o), 64'd0);
    checkOutput({tag, "_mem_ready"}, 64'(mem_data_ready_and_o), 64'd0);
    checkOutput({tag, "_mem_v"}, 64'(mem_data_v_o), 64'd0);
    checkOutput({tag, "_data_yumi"}, 64'(dma_data_yumi_o), 64'd0);
  endtask

  task automatic doReset();
    reset_n_i = 1'b0;
    rd_q.delete(); wr_q.delete();
    ptr = 0; lock = 1'b0; lock_id = 0; rd_beats = 0; wr_beats = 0;
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    setKnobs(0, 0, 0, 0, 0, 0, 0);
    applyStimulus();
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  initial begin
    logic [3:0]    order [6];
    logic [PW-1:0] pkt_b;
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0000; order[5] = 4'b0000;
    for (int i = 0; i < N; i++) begin pend_v[i] = 1'b0; pend_pkt[i] = '0; end
    @(negedge clk_i);
    asyncResetCheck("por");
    doReset();

    $display("[TB] single read from requester 2");
    setKnobs(0, 0, 100, 0, 100, 0, 0);
    pend_v[2] = 1'b1; pend_pkt[2] = makePkt(1'b0);
    applyStimulus(); modelCheck();
    checkOutput("t1_yumi", 64'(dma_pkt_yumi_o), 64'(4'b0100));
    @(negedge clk_i);
    p_mdv = 100;
    for (int b = 0; b < BB; b++) begin
      applyStimulus(); modelCheck();
      checkOutput("t1_beat_v", 64'(dma_data_v_o), 64'(4'b0100));
      @(negedge clk_i);
    end
    applyStimulus(); modelCheck();
    checkOutput("t1_empty", 64'(mem_data_ready_and_o), 64'd0);
    @(negedge clk_i);

    $display("[TB] grant lock while memory stalls");
    doReset();
    setKnobs(0, 0, 0, 0, 100, 0, 0);
    pend_v[3] = 1'b1; pend_pkt[3] = makePkt(1'b0); pkt_b = pend_pkt[3];
    applyStimulus(); modelCheck();
    checkOutput("t3_first", 64'(mem_pkt_o), 64'(pkt_b));
    @(negedge clk_i);
    pend_v[0] = 1'b1; pend_pkt[0] = makePkt(1'b0);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(); modelCheck();
      checkOutput("t3_hold", 64'(mem_pkt_o), 64'(pkt_b));
      @(negedge clk_i);
    end
    p_mpr = 100;
    applyStimulus(); modelCheck();
    checkOutput("t3_accept", 64'(dma_pkt_yumi_o), 64'(4'b1000));
    @(negedge clk_i);
    applyStimulus(); modelCheck();
    checkOutput("t3_next", 64'(dma_pkt_yumi_o), 64'(4'b0001));
    @(negedge clk_i);

    $display("[TB] round-robin order and read FIFO full");
    doReset();
    setKnobs(100, 0, 100, 0, 100, 0, 0);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(); modelCheck();
      checkOutput("t2_order", 64'(dma_pkt_yumi_o), 64'(order[c]));
      @(negedge clk_i);
    end
    p_mdv = 100;
    runCycles(20);

    $display("[TB] randomized traffic");
    setKnobs(40, 50, 60, 60, 70, 70, 60);  runCycles(400);
    setKnobs(90, 50, 100, 100, 100, 100, 100); runCycles(300);
    setKnobs(70, 30, 20, 30, 50, 50, 30);  runCycles(400);
    setKnobs(80, 50, 80, 90, 90, 100, 0);
    for (int c = 0; c < 300; c++) begin
      applyStimulus();
      mem_data_ready_and_i = c[0];
      modelCheck();
      @(negedge clk_i);
    end

    $display("[TB] reset in the middle of a read block");
    doReset();
    setKnobs(0, 0, 100, 0, 100, 0, 0);
    pend_v[1] = 1'b1; pend_pkt[1] = makePkt(1'b0);
    runCycles(1);
    p_mdv = 100;
    runCycles(3);
    asyncResetCheck("mid");
    doReset();
    setKnobs(0, 0, 100, 0, 100, 0, 0);
    pend_v[0] = 1'b1; pend_pkt[0] = makePkt(1'b0);
    pend_v[3] = 1'b1; pend_pkt[3] = makePkt(1'b0);
    applyStimulus(); modelCheck();
    checkOutput("t6_yumi", 64'(dma_pkt_yumi_o), 64'(4'b0001));
    @(negedge clk_i);
    setKnobs(0, 0, 0, 100, 100, 0, 0);
    for (int b = 0; b < BB; b++) begin
      applyStimulus(); modelCheck();
      checkOutput("t6_beat_v", 64'(dma_data_v_o), 64'(4'b0001));
      @(negedge clk_i);
    end
    applyStimulus(); modelCheck();
    checkOutput("t6_empty", 64'(mem_data_ready_and_o), 64'd0);
    @(negedge clk_i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
